e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. Sits beside the E-stage ALU and takes the same forwarded operands A and B.
- Holds the architectural HI/LO registers. The E/M register mux selects HI or LO for mfhi/mflo.
- Models a multi-cycle unit. The hazard unit stalls D on busy_or_start whenever a D-stage instruction needs the MDU.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu if enabled); legal range >=1
DIV_CYCLES, 10, busy cycles for div/divu; legal range >=1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
MDU_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; 9-15 no-op
start  input  1  qualifies MDU_op for the E-stage instruction this cycle
busy  output  1  operation in flight
busy_or_start  output  1  combinational start|busy, for stall logic
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (sync, reset=1 at posedge): HI=0, LO=0, busy=0, counter=0, operand latches=0. This takes priority over everything, including an op in flight, which is abandoned with no write.
- Accept: at a posedge with start=1, busy=0, MDU_op in 1..4 (or 7..8 if enabled):
  - latch A, B and the op;
  - set busy=1 and load the counter with N (MULT_CYCLES or DIV_CYCLES).
- Counting: busy stays high for exactly N cycles after the accept edge.
  - At the Nth edge, HI/LO are written and busy falls at that same edge.
  - The new HI/LO are visible the cycle busy reads 0.
- mthi/mtlo with start=1, busy=0: HI<=A (mthi) or LO<=A (mtlo) at that edge. Zero latency; busy stays 0.
- start=1 while busy=1: the op is ignored, with no effect on HI/LO or the counter. The hazard unit must prevent this; it must not corrupt the in-flight op.
- start=1 with MDU_op 0 or unsupported: no effect.
- Arithmetic:
  - mult: 64-bit signed product of A and B; HI=upper 32 bits, LO=lower 32 bits.
  - multu: same, unsigned.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (latched B==0): the unit still stays busy for DIV_CYCLES. HI and LO keep their previous values.
- Results are computed from the latched operands only. Changes on A/B while busy have no effect.
- The back-to-back accept edge can coincide with the busy falling edge only on the next cycle: the earliest new accept is the first edge with busy=0.

Optional Feature:
MDU_MADD_EN:
- When defined: ops 7 (madd) and 8 (maddu) are accepted like mult and take MULT_CYCLES.
  - Result {HI,LO} <= {HI,LO} + 64-bit product (signed for 7, unsigned for 8), using HI/LO as they stand at the completion edge.
  - The addition wraps modulo 2^64.
- When undefined: ops 7/8 are no-ops exactly like 9-15. No accumulator adder is synthesized.

Test Plan:
1. reset=1 for one edge after an arbitrary state -> HI=0, LO=0, busy=0. A mult started then reset at cycle 3 -> busy=0, HI/LO=0 at the next cycle, no later write.
2. mult A=0xFFFFFFFD (-3), B=5, start 1 cycle -> busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE.
3. div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. HI=0x11, LO=0x22, divu A=7, B=0 -> busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
5. div starts; at busy cycle 2 assert start with mult 2*3 and change A/B -> ignored. Final result matches the original div; busy_or_start=1 throughout.
6. mthi A=0xDEAD then mtlo A=0xBEEF on consecutive cycles -> HI=0xDEAD, LO=0xBEEF, busy never asserted. With MDU_MADD_EN, madd A=2, B=3 -> {HI,LO}=0x0000DEAD_0000BEF5 after 5 cycles.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu -- execute-stage multiply/divide unit holding the architectural HI/LO pair.
// Latency: mult/multu (and madd/maddu) take MULT_CYCLES, div/divu take DIV_CYCLES; mthi/mtlo write at the start edge.
// Backpressure: busy/busy_or_start let the hazard unit stall D; any start seen while busy is ignored.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   A, B              forwarded rs/rt operands
//   MDU_op, start     operation code and its qualifier for the E-stage instruction
//   busy              a multi-cycle operation is in flight
//   busy_or_start     start | busy, for the decode-stage stall logic
//   HI, LO            architectural HI/LO registers
//
// Optional feature: define MDU_MADD_EN to accept madd (7) / maddu (8). The 64-bit
// accumulate adder only exists when the macro is defined; otherwise ops 7/8 are no-ops.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDU_op,
  input  logic        start,
  output logic        busy,
  output logic        busy_or_start,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  // Architectural state and in-flight operation.
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;

  // Decode of the incoming op.
  logic in_is_mul;
  logic in_is_div;
  logic idle;
  logic accept;
  logic last_cycle;

  // Datapath results derived from the latched operands.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_den_s;
  logic [31:0] div_den_u;
  logic [31:0] uq_s, ur_s;
  logic [31:0] q_u, r_u;
  logic [31:0] q_s, r_s;
  logic        b_zero;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;

  assign busy          = (cnt_q != '0);
  assign busy_or_start = start | busy;
  assign HI            = hi_q;
  assign LO            = lo_q;

  assign idle       = ~busy;
  assign last_cycle = (cnt_q == CNT_ONE);

  always_comb begin
    in_is_mul = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
`ifdef MDU_MADD_EN
    in_is_mul = in_is_mul || (MDU_op == OP_MADD) || (MDU_op == OP_MADDU);
`endif
    in_is_div = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
  end

  assign accept = start & idle & (in_is_mul | in_is_div);

  // Multiplies: sign- or zero-extend to 64 bits; the low 64 bits of the
  // extended product are the exact two's-complement result.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide works on magnitudes so 0x80000000 / -1 falls out naturally:
  // |a| = 2^31 fits as an unsigned value and the quotient re-negates to 0x80000000.
  assign b_zero    = (b_q == 32'd0);
  assign abs_a     = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign abs_b     = b_q[31] ? (~b_q + 32'd1) : b_q;
  // Divisor is forced non-zero so the divider never sees x/0; the result is discarded then anyway.
  assign div_den_s = b_zero ? 32'd1 : abs_b;
  assign div_den_u = b_zero ? 32'd1 : b_q;
  assign uq_s      = abs_a / div_den_s;
  assign ur_s      = abs_a % div_den_s;
  assign q_u       = a_q / div_den_u;
  assign r_u       = a_q % div_den_u;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign q_s       = (a_q[31] ^ b_q[31]) ? (~uq_s + 32'd1) : uq_s;
  assign r_s       = a_q[31] ? (~ur_s + 32'd1) : ur_s;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      OP_DIV: begin
        res_hi = r_s;
        res_lo = q_s;
        res_wr = ~b_zero;
      end
      OP_DIVU: begin
        res_hi = r_u;
        res_lo = q_u;
        res_wr = ~b_zero;
      end
`ifdef MDU_MADD_EN
      // Accumulates onto HI/LO as they stand at the completion edge, wrapping mod 2^64.
      OP_MADD: begin
        {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
        res_wr = 1'b1;
      end
      OP_MADDU: begin
        {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
        res_wr = 1'b1;
      end
`endif
      default: begin
        res_wr = 1'b0;
      end
    endcase
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;

    if (accept) begin
      a_d   = A;
      b_d   = B;
      op_d  = MDU_op;
      cnt_d = in_is_div ? DIV_N : MULT_N;
    end else if (busy) begin
      // Result lands on the same edge that busy drops.
      cnt_d = cnt_q - CNT_ONE;
      if (last_cycle && res_wr) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end

    // Moves to HI/LO only while idle, so an in-flight result is never disturbed.
    if (start && idle) begin
      if (MDU_op == OP_MTHI) begin
        hi_d = A;
      end else if (MDU_op == OP_MTLO) begin
        lo_d = A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      cnt_q <= '0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu -- directed bench for e_mdu with an expected-result scoreboard.
// Latency: checks busy length against MULT_CYCLES/DIV_CYCLES per op.
// Backpressure: exercises start-while-busy being ignored.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDU_op;
  logic        start;
  logic        busy;
  logic        busy_or_start;
  logic [31:0] HI;
  logic [31:0] LO;

  int passed;
  int failed;
  int total;

  res_t sb[$];

  e_mdu #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .A            (A),
    .B            (B),
    .MDU_op       (MDU_op),
    .start        (start),
    .busy         (busy),
    .busy_or_start(busy_or_start),
    .HI           (HI),
    .LO           (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle start pulse for a zero-latency op or a no-op.
  task automatic pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    A      = a;
    B      = b;
    MDU_op = op;
    start  = 1'b1;
    step();
    start  = 1'b0;
    MDU_op = 4'd0;
  endtask

  // Start a multi-cycle op with its expected result queued.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    sb.push_back({exp_hi, exp_lo});
    pulse(op, a, b);
  endtask

  // Counts the remaining busy cycles (bounded), then pops and checks the result.
  task automatic finish_long(input string tag, input int n, input int already);
    int   cyc;
    logic bos_ok;
    res_t e;
    cyc    = 0;
    bos_ok = 1'b1;
    while (busy === 1'b1 && cyc < 200) begin
      if (busy_or_start !== 1'b1) bos_ok = 1'b0;
      cyc++;
      step();
    end
    chk({tag, "_cycles"}, 32'(cyc + already), 32'(n));
    chk({tag, "_bos"}, {31'd0, bos_ok}, 32'd1);
    if (sb.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, HI, e.hi);
      chk({tag, "_lo"}, LO, e.lo);
    end
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    MDU_op = 4'd0;
    A      = 32'd0;
    B      = 32'd0;
    step();
    step();
    reset = 1'b0;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("idle_bos", {31'd0, busy_or_start}, 32'd0);

    // Reset from an arbitrary state.
    pulse(4'd5, 32'h1234, 32'd0);
    chk("mthi_pre", HI, 32'h1234);
    pulse(4'd6, 32'h5678, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_hi", HI, 32'd0);
    chk("rst2_lo", LO, 32'd0);

    // Reset abandons an in-flight mult with no later write.
    pulse(4'd1, 32'd7, 32'd9);
    chk("mult_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (8) step();
    chk("abort_late_hi", HI, 32'd0);
    chk("abort_late_lo", LO, 32'd0);

    // Multiplies.
    launch(4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    chk("mult_busy1", {31'd0, busy}, 32'd1);
    finish_long("mult", MC, 0);
    launch(4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    finish_long("multu", MC, 0);

    // Divides.
    launch(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    finish_long("div", DC, 0);
    launch(4'd4, 32'd7, 32'd2, 32'd1, 32'd3);
    finish_long("divu", DC, 0);
    launch(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    finish_long("div_ovf", DC, 0);

    // Divide by zero leaves HI/LO untouched.
    pulse(4'd5, 32'h11, 32'd0);
    pulse(4'd6, 32'h22, 32'd0);
    launch(4'd4, 32'd7, 32'd0, 32'h11, 32'h22);
    finish_long("divz", DC, 0);

    // Start while busy plus operand churn: ignored. -100 / 7 -> q=-14, r=-2.
    launch(4'd3, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
    step();
    A      = 32'd2;
    B      = 32'd3;
    MDU_op = 4'd1;
    start  = 1'b1;
    chk("ign_bos", {31'd0, busy_or_start}, 32'd1);
    step();
    start  = 1'b0;
    MDU_op = 4'd0;
    A      = 32'h55;
    B      = 32'd0;
    finish_long("ign_div", DC, 2);
    step();
    chk("ign_idle", {31'd0, busy}, 32'd0);

    // Moves: zero latency, busy never rises.
    pulse(4'd5, 32'hDEAD, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    pulse(4'd6, 32'hBEEF, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'hDEAD);
    chk("mtlo_lo", LO, 32'hBEEF);

    // No-op codes.
    pulse(4'd0, 32'hFFFF, 32'd1);
    pulse(4'd12, 32'hFFFF, 32'd1);
    chk("noop_busy", {31'd0, busy}, 32'd0);
    chk("noop_hi", HI, 32'hDEAD);
    chk("noop_lo", LO, 32'hBEEF);

`ifdef MDU_MADD_EN
    launch(4'd7, 32'd2, 32'd3, 32'h0000DEAD, 32'h0000BEF5);
    finish_long("madd", MC, 0);
`else
    pulse(4'd7, 32'd2, 32'd3);
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    chk("madd_off_hi", HI, 32'hDEAD);
    chk("madd_off_lo", LO, 32'hBEEF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
